leading_one: RTL and testbench
==============================

LEADING_ONE -- requirements
Module: leading_one

Interface
REQ-001 Parameter WIDTH, default 9, input vector width; only 9 is verified.
REQ-002 Parameter IDX_W, default 5, index width.
REQ-003 Parameter ZERO_CODE, default 5'b11111, index code for an all-zero input.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port clk  input  1  rising-edge clock for the registered outputs.
REQ-006 Port rst  input  1  asynchronous active-high reset.
REQ-007 Port a  input  9  vector to scan.
REQ-008 Port index  output  5  combinational bit position of the most-significant 1 in a.
REQ-009 Port index_q  output  5  index registered on clk.
REQ-010 Port zero_q  output  1  registered flag, set when a == 0.

Function
REQ-011 index SHALL be purely combinational, with zero latency, and SHALL NOT depend on clk or rst.
REQ-012 index SHALL equal n when a[n] == 1 and a[8:n+1] == 0, for n = 0..8.
REQ-013 index SHALL equal ZERO_CODE (31) when a == 0.
REQ-014 Lower bits SHALL be ignored: any a in [2^n, 2^(n+1)-1] yields n.
REQ-015 index SHALL never take the values 9..30.
REQ-016 On each rising clk edge with rst low, index_q SHALL take the current index value.
REQ-017 On each rising clk edge with rst low, zero_q SHALL take (a == 0).
REQ-018 The registered path SHALL have exactly one cycle of latency.
REQ-019 The block SHALL have no handshake, no enable and no internal state beyond index_q and zero_q.
REQ-020 index SHALL settle within one combinational delay of any change on a, with no glitch requirement.
REQ-021 X or Z on a MAY propagate to the outputs; no X-masking is required.

Reset
REQ-022 While rst is high, index_q SHALL be 31 and zero_q SHALL be 1, immediately and without waiting for a clk edge.
REQ-023 Deasserting rst SHALL cause no output change until the next rising clk edge, which loads the values in REQ-016 and REQ-017.
REQ-024 rst SHALL NOT affect the combinational index output.

Structure
REQ-025 The constants WIDTH, IDX_W and ZERO_CODE SHALL live in the shared package leading_one_pkg.
REQ-026 The priority encoder SHALL be one combinational sub-module, leading_one_enc (a[8:0] -> index[4:0]).
REQ-027 The top level SHALL instantiate leading_one_enc once, drive index from it, and add the index_q and zero_q flops.
REQ-028 The encoder SHALL be a two-level tree: two 4-bit encoders for a[7:4] and a[3:0], plus explicit priority for a[8].

Verification
REQ-029 a = 0 -> index = 31; one cycle later, index_q = 31 and zero_q = 1.
REQ-030 a = 1 -> index = 0; a = 9'h002 -> index = 1; a = 9'h003 -> index = 1.
REQ-031 a = 9'h100 -> index = 8; a = 9'h1FF -> index = 8; a = 9'h0FF -> index = 7.
REQ-032 a = 9'b000101000 (40) -> index = 5; a = 9'h010 -> index = 4; a = 9'h00F -> index = 3.
REQ-033 Exhaustive sweep with a = 0..511, one value every 2 ns: index SHALL match a behavioural range-compare model every time, and the mismatch status flag SHALL remain 0.
REQ-034 Assert rst mid-sweep with a = 9'h080 -> index_q = 31 and zero_q = 1 immediately, while index stays 7; release rst -> after the next rising clk edge, index_q = 7 and zero_q = 0.

Source files
------------

// File: rtl/leading_one_pkg.sv
// Shared constants and the 4-bit priority-encode helper for the leading-one finder.
package leading_one_pkg;
  localparam int WIDTH = 9;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] ZERO_CODE = 5'b11111;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } enc4_t;

  // Position of the highest set bit in a nibble; vld is low for an empty nibble.
  function automatic enc4_t enc4(input logic [3:0] v);
    enc4_t r;
    r.vld = |v;
    if (v[3])      r.idx = 2'd3;
    else if (v[2]) r.idx = 2'd2;
    else if (v[1]) r.idx = 2'd1;
    else           r.idx = 2'd0;
    return r;
  endfunction
endpackage

// File: rtl/leading_one_enc.sv
// Combinational 9-bit leading-one encoder: bit 8 wins outright, then two nibble encoders.
module leading_one_enc
  import leading_one_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  output logic [IDX_W-1:0] index
);
  enc4_t hi, lo;

  always_comb begin
    hi = enc4(a[7:4]);
    lo = enc4(a[3:0]);
    if (a[8])        index = 5'd8;
    else if (hi.vld) index = {3'b001, hi.idx};
    else if (lo.vld) index = {3'b000, lo.idx};
    else             index = ZERO_CODE;
  end
endmodule

// File: rtl/leading_one.sv
// Leading-one finder: combinational index plus a registered copy and an all-zero flag.
module leading_one #(
  parameter int                WIDTH     = leading_one_pkg::WIDTH,
  parameter int                IDX_W     = leading_one_pkg::IDX_W,
  parameter logic [IDX_W-1:0]  ZERO_CODE = leading_one_pkg::ZERO_CODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] index_q,
  output logic             zero_q
);
  logic [IDX_W-1:0] index_d;
  logic             zero_d;

  leading_one_enc u_enc (
    .a     (a),
    .index (index)
  );

  assign index_d = index;
  assign zero_d  = (a == '0);

  // Reset state reports "empty" so downstream sees a consistent no-one code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= ZERO_CODE;
      zero_q  <= 1'b1;
    end else begin
      index_q <= index_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_leading_one.sv
// Directed vectors, exhaustive sweep and mid-sweep reset for leading_one.
`timescale 1ns/100ps
module tb_leading_one;
  logic       clk, rst;
  logic [8:0] a;
  logic [4:0] index, index_q;
  logic       zero_q;

  int total = 0, bad = 0;
  int sweep_mism = 0;
  bit chk_on = 0;
  bit loaded = 0;
  int last_a = 0;

  leading_one dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .index   (index),
    .index_q (index_q),
    .zero_q  (zero_q)
  );

  initial begin
    clk = 0;
    forever #1 clk = ~clk;
  end

  // Range-compare model: n such that 2^n <= v < 2^(n+1), else 31.
  function automatic int model(input int v);
    for (int n = 8; n >= 0; n--)
      if (v >= (1 << n) && v < (1 << (n + 1))) return n;
    return 31;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (a=%0d t=%0t)", name, act, exp, a, $time);
    end
  endtask

  // Registered-path model: what index_q/zero_q must hold after the last loading edge.
  always @(posedge clk) begin
    if (!rst) begin
      last_a = int'(a);
      loaded = 1;
    end
  end
  always @(posedge rst) loaded = 0;

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      int e_iq, e_zq;
      if (rst || !loaded) begin e_iq = 31; e_zq = 1; end
      else begin e_iq = model(last_a); e_zq = (last_a == 0); end
      if (int'(index) != model(int'(a))) sweep_mism++;
      check("index", int'(index), model(int'(a)));
      check("index_q", int'(index_q), e_iq);
      check("zero_q", int'(zero_q), e_zq);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  int vec_a[10]   = '{0, 1, 9'h002, 9'h003, 9'h100, 9'h1FF, 9'h0FF, 40, 9'h010, 9'h00F};
  int vec_exp[10] = '{31, 0, 1, 1, 8, 8, 7, 5, 4, 3};

  initial begin
    rst = 1;
    a   = 9'h000;
    // Pin the model with hand-computed values.
    check("model_0", model(0), 31);
    check("model_511", model(511), 8);
    check("model_40", model(40), 5);
    check("model_255", model(255), 7);
    #0.5;
    check("rst_index_q", int'(index_q), 31);
    check("rst_zero_q", int'(zero_q), 1);
    @(posedge clk); #0.5;
    rst = 0;
    chk_on = 1;

    foreach (vec_a[i]) begin
      @(posedge clk); #0.5;
      a = 9'(vec_a[i]);
      #0.2;
      check("dir_index", int'(index), vec_exp[i]);
      @(posedge clk); #0.5;
      check("dir_index_q", int'(index_q), vec_exp[i]);
      check("dir_zero_q", int'(zero_q), (vec_a[i] == 0) ? 1 : 0);
    end

    sweep_mism = 0;
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #0.5;
      a = 9'(i);
      if (i == 128) begin
        #0.2;
        rst = 1;
        #0.1;
        check("midrst_index_q", int'(index_q), 31);
        check("midrst_zero_q", int'(zero_q), 1);
        check("midrst_index", int'(index), 7);
        @(posedge clk); #0.5;
        rst = 0;
        #0.1;
        check("release_hold_index_q", int'(index_q), 31);
        check("release_hold_zero_q", int'(zero_q), 1);
        @(posedge clk); #0.5;
        check("release_index_q", int'(index_q), 7);
        check("release_zero_q", int'(zero_q), 0);
      end
    end
    @(posedge clk); #0.5;
    check("sweep_flag", sweep_mism, 0);
    chk_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
